// File: rtl/pf_sched_pkg.sv
// Shared types for the prefetch memory scheduler: FSM states, line-address
// type and line-granular address helpers.
package pf_sched_pkg;

  localparam int LINE_OFFSET = 5;

  typedef logic [31-LINE_OFFSET:0] line_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEM_RD,
    ST_DEM_WR,
    ST_HIT_RESP,
    ST_PF_RD
  } pf_sched_state_t;

  function automatic line_addr_t to_line(input logic [31:0] addr);
    return addr[31:LINE_OFFSET];
  endfunction

  function automatic logic line_eq(input line_addr_t a, input line_addr_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/pf_queue.sv
// Circular prefetch queue with per-entry valid bits, duplicate detection,
// pop that skips invalidated slots, and a match-invalidate port.
module pf_queue
  import pf_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  line_addr_t push_line_i,
  input  logic       push_block_i,
  input  logic       pop_i,
  input  logic       inv_i,
  input  line_addr_t inv_line_i,
  output logic       pop_vld_o,
  output line_addr_t pop_line_o,
  output logic       dup_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  line_addr_t       line_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, pop_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d, pop_off;
  logic             found, do_push;

  // First valid slot at or after the head; slots before it are freed on pop.
  always_comb begin
    found   = 1'b0;
    pop_off = '0;
    pop_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && vld_q[head_q + PTR_W'(i)]) begin
        found   = 1'b1;
        pop_off = CNT_W'(i);
        pop_idx = head_q + PTR_W'(i);
      end
    end
  end

  always_comb begin
    dup_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && line_eq(line_q[i], push_line_i)) dup_o = 1'b1;
    end
  end

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign pop_vld_o  = found;
  assign pop_line_o = line_q[pop_idx];
  assign do_push    = push_i && !dup_o && !push_block_i && !full_o;

  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (inv_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (line_eq(line_q[i], inv_line_i)) vld_d[i] = 1'b0;
      end
    end
    if (pop_i && found) begin
      vld_d[pop_idx] = 1'b0;
      head_d         = pop_idx + PTR_W'(1);
      cnt_d          = cnt_q - (pop_off + CNT_W'(1));
    end else if (!empty_o && !vld_q[head_q]) begin
      // An invalidated slot at the head is released without waiting for a pop.
      head_d = head_q + PTR_W'(1);
      cnt_d  = cnt_q - CNT_W'(1);
    end
    if (do_push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PTR_W'(1);
      cnt_d         = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) line_q[tail_q] <= push_line_i;
  end

endmodule

// File: rtl/prefetch_mem_scheduler.sv
// Arbitrates the pmem port between demand traffic and queued stride prefetches;
// the last prefetched line is kept in a one-line buffer to serve demand hits.
module prefetch_mem_scheduler
  import pf_sched_pkg::*;
#(
  parameter int PF_DEPTH = 4,
  parameter int LINE_W   = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pf_addr,
  input  logic              pf_en,
  input  logic [31:0]       dem_address,
  input  logic              dem_read,
  input  logic              dem_write,
  input  logic [LINE_W-1:0] dem_wdata,
  output logic [LINE_W-1:0] dem_rdata,
  output logic              dem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              pf_hit,
  output logic              pf_drop
);

  pf_sched_state_t   state_q, state_d;
  line_addr_t        addr_q, addr_d;
  logic              buf_vld_q, buf_vld_d, buf_load;
  line_addr_t        buf_tag_q;
  logic [LINE_W-1:0] buf_data_q;
  logic              pf_hit_q, pf_drop_q, hit_go, pf_drop_d;
  line_addr_t        dem_line, pf_line, q_pop_line;
  logic              q_pop, q_inv, q_pop_vld, q_dup, q_full, q_empty, pf_block;
  logic              unused_low_bits;

  assign dem_line        = to_line(dem_address);
  assign pf_line         = to_line(pf_addr);
  assign unused_low_bits = ^{pf_addr[LINE_OFFSET-1:0], dem_address[LINE_OFFSET-1:0]};

  // Lines already buffered, in flight, or about to be demand-fetched are not queued.
  assign pf_block = (buf_vld_q && line_eq(buf_tag_q, pf_line)) ||
                    (((state_q == ST_PF_RD) || (state_q == ST_DEM_RD)) && line_eq(addr_q, pf_line)) ||
                    (q_inv && line_eq(dem_line, pf_line));
  assign pf_drop_d = pf_en && !pf_block && !q_dup && q_full;

  pf_queue #(.DEPTH(PF_DEPTH)) u_queue (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (pf_en),
    .push_line_i (pf_line),
    .push_block_i(pf_block),
    .pop_i       (q_pop),
    .inv_i       (q_inv),
    .inv_line_i  (dem_line),
    .pop_vld_o   (q_pop_vld),
    .pop_line_o  (q_pop_line),
    .dup_o       (q_dup),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    buf_vld_d = buf_vld_q;
    buf_load  = 1'b0;
    q_pop     = 1'b0;
    q_inv     = 1'b0;
    hit_go    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dem_read) begin
          if (buf_vld_q && line_eq(buf_tag_q, dem_line)) begin
            state_d = ST_HIT_RESP;
            hit_go  = 1'b1;
          end else begin
            state_d = ST_DEM_RD;
            addr_d  = dem_line;
            q_inv   = 1'b1;
          end
        end else if (dem_write) begin
          state_d = ST_DEM_WR;
          addr_d  = dem_line;
          if (buf_vld_q && line_eq(buf_tag_q, dem_line)) buf_vld_d = 1'b0;
        end else if (q_pop_vld && !q_empty) begin
          state_d = ST_PF_RD;
          addr_d  = q_pop_line;
          q_pop   = 1'b1;
        end
      end
      ST_DEM_RD, ST_DEM_WR: if (pmem_resp) state_d = ST_IDLE;
      ST_HIT_RESP:          state_d = ST_IDLE;
      ST_PF_RD: begin
        if (pmem_resp) begin
          buf_load  = 1'b1;
          buf_vld_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    dem_resp     = 1'b0;
    dem_rdata    = '0;
    case (state_q)
      ST_DEM_RD: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_q, {LINE_OFFSET{1'b0}}};
        if (pmem_resp) begin
          dem_resp  = 1'b1;
          dem_rdata = pmem_rdata;
        end
      end
      ST_DEM_WR: begin
        pmem_write   = 1'b1;
        pmem_address = {addr_q, {LINE_OFFSET{1'b0}}};
        pmem_wdata   = dem_wdata;
        dem_resp     = pmem_resp;
      end
      ST_HIT_RESP: begin
        dem_resp  = 1'b1;
        dem_rdata = buf_data_q;
      end
      ST_PF_RD: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_q, {LINE_OFFSET{1'b0}}};
      end
      default: ;
    endcase
  end

  assign pf_hit  = pf_hit_q;
  assign pf_drop = pf_drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      buf_vld_q <= 1'b0;
      pf_hit_q  <= 1'b0;
      pf_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_vld_q <= buf_vld_d;
      pf_hit_q  <= hit_go;
      pf_drop_q <= pf_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (buf_load) begin
      buf_tag_q  <= addr_q;
      buf_data_q <= pmem_rdata;
    end
  end

endmodule

// File: doc/prefetch_mem_scheduler.md
# prefetch_mem_scheduler

Schedules the single physical-memory port between demand traffic from the L2 eviction write buffer and stride prefetches generated by the RPT. Demand requests always win. Prefetches are queued and issued only when the port is idle. The most recently prefetched line is held in a one-line prefetch buffer, so a demand read that hits it completes without a memory access. The block sits between `eviction_write_buffer` (demand side) and pmem.

## Interface
Parameters:
- `PF_DEPTH`, 4: prefetch queue entries (power of two, ≥2).
- `LINE_W`, 256: line width in bits.

Ports:
- `clk`, in, 1: clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `pf_addr`, in, 32: prefetch candidate address (RPT `ORB`).
- `pf_en`, in, 1: one-cycle prefetch request strobe.
- `dem_address`, in, 32: demand address.
- `dem_read`, in, 1: demand read request (level).
- `dem_write`, in, 1: demand write request (level).
- `dem_wdata`, in, LINE_W: demand write data.
- `dem_rdata`, out, LINE_W: demand read data.
- `dem_resp`, out, 1: demand completion.
- `pmem_address`, out, 32: memory address, line-aligned (`[4:0]`=0).
- `pmem_read`, out, 1: memory read request.
- `pmem_write`, out, 1: memory write request.
- `pmem_wdata`, out, LINE_W: memory write data.
- `pmem_rdata`, in, LINE_W: memory read data.
- `pmem_resp`, in, 1: memory completion.
- `pf_hit`, out, 1: one-cycle pulse when a demand read is served from the prefetch buffer.
- `pf_drop`, out, 1: one-cycle pulse when a `pf_en` is discarded because the queue is full.

## Operation
- Line address: `addr[31:5]`. All compares use line address only.
- FSM states: IDLE, DEM_RD, DEM_WR, HIT_RESP, PF_RD.
- IDLE priority:
  1. `dem_read` with a valid buffer line equal to the demand line: go to HIT_RESP.
  2. `dem_read` otherwise: go to DEM_RD.
  3. `dem_write`: go to DEM_WR. The buffer is invalidated on entry if its line matches.
  4. Queue holds a valid entry: pop it and go to PF_RD.
  5. Otherwise stay in IDLE.
- DEM_RD:
  - `pmem_read`=1, `pmem_address`=demand line.
  - On `pmem_resp`: `dem_resp`=1 that cycle, `dem_rdata`=`pmem_rdata`, return to IDLE.
  - On entry, all queue entries matching the demand line are invalidated.
- DEM_WR:
  - `pmem_write`=1, `pmem_wdata`=`dem_wdata`.
  - On `pmem_resp`: `dem_resp`=1 that cycle, return to IDLE.
- HIT_RESP:
  - `dem_resp`=1, `dem_rdata`=buffer data, `pf_hit`=1, then IDLE.
  - The buffer stays valid.
- PF_RD:
  - `pmem_read`=1 for the popped line. The transaction is non-preemptible.
  - On `pmem_resp`: buffer is loaded with tag and data and marked valid (it overwrites the previous line), then IDLE.
  - Demand requests arriving during PF_RD wait. If the demand is for the same line, it hits in HIT_RESP afterwards.
- Queue push on `pf_en`:
  - Discarded silently if the line matches any valid queue entry, the valid buffer line, or the line currently in flight in PF_RD/DEM_RD.
  - Else, if the queue is full, `pf_drop`=1 and the request is discarded.
  - Else the line is written at the tail with valid=1.
- Queue structure:
  - Circular buffer with per-entry valid bits. Pop skips invalid entries.
  - Occupancy counts allocated slots. An invalidated slot is freed when the head passes it.
- Simultaneous push and pop: fullness is evaluated before the pop, so a full queue drops the push.
- Demand-side contract: the requester holds `dem_read`/`dem_write` until `dem_resp` and deasserts the cycle after. IDLE therefore never re-triggers on a completed request.
- `dem_read` and `dem_write` are never high together.

## Timing
- Reset values:
  - All outputs 0. `dem_rdata` and `pmem_wdata` are 0.
  - FSM in IDLE, queue empty, buffer invalid.
- Reset asserted mid-transaction forces `pmem_read`/`pmem_write` low immediately (asynchronously). The pending demand is not answered.
- Hit latency: request seen in IDLE at cycle N, `dem_resp` at N+1.
- Miss/write latency: `pmem_*` asserted at N+1, `dem_resp` in the same cycle as `pmem_resp`.
- Prefetch issue: earliest one cycle after the push, and only when IDLE sees no demand.
- `pmem_read`/`pmem_write` are held stable with a constant address until `pmem_resp`. Both are low in IDLE and HIT_RESP.
- `pf_hit`/`pf_drop` are registered single-cycle pulses.

## Structure
- Package `pf_sched_pkg`:
  - State enum `pf_sched_state_t`.
  - `LINE_OFFSET`=5.
  - `line_addr_t` (27 bits).
  - Line-compare function.
- Sub-module `pf_queue`:
  - Circular buffer with valid bits.
  - Push with duplicate check, pop-skip-invalid, match-invalidate port, full/empty flags.
- The top holds the FSM, the prefetch buffer and the output muxing.

## Test plan
- Reset, then `pf_en` with 0x1000 while idle → `pmem_read` with 0x1000 two cycles later. After `pmem_resp`, `dem_read` of 0x1010 → `dem_resp` next cycle, data equals the prefetched line, `pf_hit`=1, no `pmem_read`.
- Demand read 0x2000 in the same cycle as `pf_en` 0x3000 → demand issued first. The prefetch of 0x3000 issues only after `dem_resp`.
- Five distinct `pf_en` (0x100, 0x200, 0x300, 0x400, 0x500) while a demand read is stalled → first four queued, fifth gives `pf_drop`=1. Duplicate 0x200 gives no `pf_drop` and no second issue.
- 0x4000 queued, then demand read of 0x4000 issued first → queue entry invalidated, no prefetch of 0x4000 follows.
- Buffer holds 0x5000, demand write to 0x5008 → `pmem_write` at 0x5000, buffer invalidated. A later `dem_read` of 0x5000 goes to pmem.
- `reset` asserted while in PF_RD → `pmem_read`=0 in the same cycle. After release: queue empty, buffer invalid.
